// File: rtl/instr_fetch.sv
// Instruction fetch stage: pc sequencing, 1-cycle imem reads, stall skid buffer, jump redirect.
// Optional HALT on opcode 8'hFF when IFETCH_HALT_EN is defined.
module instr_fetch #(
  parameter int         PC_W     = 8,
  parameter logic [7:0] NOP_CODE = 8'h80
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_target,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [7:0]      imem_rdata,
  output logic [7:0]      instr_code,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid,
  output logic            halted
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  logic [1:0]      state;
  logic [PC_W-1:0] pc;
  logic            rsp_pend;
  logic [PC_W-1:0] rsp_pc;
  logic            skid_vld;
  logic [7:0]      skid_code;
  logic [PC_W-1:0] skid_pc;

  logic            run_ok;
  logic            halt_ld;
  logic            drain;
  logic            ld_vld;
  logic [7:0]      ld_code;
  logic [PC_W-1:0] ld_pc;

`ifdef IFETCH_HALT_EN
  assign run_ok  = (state != HALT);
  assign halted  = (state == HALT);
  assign halt_ld = ld_vld && (ld_code == 8'hFF);
`else
  assign run_ok  = 1'b1;
  assign halted  = 1'b0;
  assign halt_ld = 1'b0;
`endif

  assign imem_addr = pc;
  assign imem_rd   = run_ok && !stall && !jmp;

  // A full skid is always older than any response, so it drains first.
  always_comb begin
    drain   = (state == STALL) && skid_vld;
    ld_vld  = drain || rsp_pend;
    ld_code = drain ? skid_code : imem_rdata;
    ld_pc   = drain ? skid_pc : rsp_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      pc          <= '0;
      rsp_pend    <= 1'b0;
      rsp_pc      <= '0;
      skid_vld    <= 1'b0;
      skid_code   <= NOP_CODE;
      skid_pc     <= '0;
      instr_code  <= NOP_CODE;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (!run_ok) begin
      rsp_pend    <= 1'b0;
      skid_vld    <= 1'b0;
      instr_code  <= NOP_CODE;
      instr_valid <= 1'b0;
    end else if (jmp) begin
      state       <= RUN;
      pc          <= jmp_target;
      rsp_pend    <= 1'b0;
      skid_vld    <= 1'b0;
      instr_code  <= NOP_CODE;
      instr_valid <= 1'b0;
    end else if (stall) begin
      state    <= STALL;
      rsp_pend <= 1'b0;
      if (rsp_pend) begin
        skid_vld  <= 1'b1;
        skid_code <= imem_rdata;
        skid_pc   <= rsp_pc;
      end
    end else begin
      state    <= halt_ld ? HALT : RUN;
      pc       <= pc + PC_W'(1);
      rsp_pend <= 1'b1;
      rsp_pc   <= pc;
      skid_vld <= 1'b0;
      if (ld_vld) begin
        instr_code  <= ld_code;
        instr_pc    <= ld_pc;
        instr_valid <= 1'b1;
      end else begin
        instr_code  <= NOP_CODE;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model, queue-based fetch model checked every cycle,
// plus directed literal checks for reset, stall, jump, wrap, reset pulse and 8'hFF handling.
module tb_instr_fetch;

  localparam logic [7:0] NOP = 8'h80;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall, jmp;
  logic [7:0] jmp_target;
  logic [7:0] imem_addr;
  logic       imem_rd;
  logic [7:0] imem_rdata = 8'hEE;
  logic [7:0] instr_code;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       halted;

  instr_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .jmp(jmp), .jmp_target(jmp_target),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata),
    .instr_code(instr_code), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .halted(halted)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];

  // Memory: data for a sampled address is presented for the cycle after the edge.
  always @(posedge clk) begin
    if (imem_rd) imem_rdata <= mem[imem_addr];
    else         imem_rdata <= 8'hEE;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owed instructions are a FIFO of addresses; stalling just leaves them owed.
  logic [7:0] m_pc;
  logic [7:0] m_code;
  logic [7:0] m_opc;
  logic       m_vld;
  logic       m_halt;
  logic [7:0] pend [$];

  task automatic model_reset();
    m_pc = 8'h00; m_code = NOP; m_opc = 8'h00; m_vld = 1'b0; m_halt = 1'b0;
    pend.delete();
  endtask

  initial begin
    logic upd;
    logic [7:0] a;
    forever begin
      @(negedge clk);
      upd = rst;
      if (rst) begin
        chk("imem_rd", imem_rd, !m_halt && !stall && !jmp);
        chk("imem_addr", imem_addr, m_pc);
        if (m_halt) begin
          m_vld = 1'b0; m_code = NOP; pend.delete();
        end else if (jmp) begin
          pend.delete(); m_vld = 1'b0; m_code = NOP; m_pc = jmp_target;
        end else if (!stall) begin
          if (pend.size() > 0) begin
            a = pend.pop_front();
            m_code = mem[a]; m_opc = a; m_vld = 1'b1;
`ifdef IFETCH_HALT_EN
            if (m_code == 8'hFF) m_halt = 1'b1;
`endif
          end else begin
            m_vld = 1'b0; m_code = NOP;
          end
          chk("owed_depth", pend.size(), 0);
          pend.push_back(m_pc);
          m_pc = m_pc + 8'd1;
        end
      end
      @(posedge clk); #1;
      if (upd && rst) begin
        chk("instr_code", instr_code, m_code);
        chk("instr_valid", instr_valid, m_vld);
        if (m_vld) chk("instr_pc", instr_pc, m_opc);
        chk("halted", halted, m_halt);
      end
    end
  end

  task automatic tick(input logic s, input logic j, input logic [7:0] t);
    stall = s; jmp = j; jmp_target = t;
    @(posedge clk); #2;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; jmp = 1'b0; jmp_target = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'hA5] = 8'h11;
    mem[0] = 8'h0A; mem[1] = 8'h53; mem[2] = 8'h21; mem[3] = 8'h33;
    mem[8'h40] = 8'h9C; mem[8'hFF] = 8'hE7;
    model_reset();
    @(posedge clk); #2;
    chk("rst_code", instr_code, NOP);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_halted", halted, 0);
    rst = 1'b1;

    // Reset release: 0A/53/21 on edges 2/3/4
    tick(0, 0, 0);
    chk("e1_valid", instr_valid, 0);
    tick(0, 0, 0);
    chk("e2_code", instr_code, 8'h0A); chk("e2_pc", instr_pc, 0); chk("e2_valid", instr_valid, 1);
    tick(0, 0, 0);
    chk("e3_code", instr_code, 8'h53); chk("e3_pc", instr_pc, 1);
    tick(0, 0, 0);
    chk("e4_code", instr_code, 8'h21); chk("e4_pc", instr_pc, 2);

    // Three-cycle stall with address 3 in flight
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0);
      chk("stall_hold_pc", instr_pc, 2);
      chk("stall_hold_code", instr_code, 8'h21);
      chk("stall_hold_addr", imem_addr, 4);
    end
    tick(0, 0, 0);
    chk("drain_pc", instr_pc, 3); chk("drain_code", instr_code, 8'h33);
    tick(0, 0, 0);
    chk("after_drain_pc", instr_pc, 4); chk("after_drain_code", instr_code, 8'h5E);

    // Jump together with stall to 0x40
    tick(1, 1, 8'h40);
    chk("jmp_e0_valid", instr_valid, 0); chk("jmp_e0_code", instr_code, NOP);
    tick(0, 0, 0);
    chk("jmp_e1_valid", instr_valid, 0); chk("jmp_e1_code", instr_code, NOP);
    tick(0, 0, 0);
    chk("jmp_e2_code", instr_code, 8'h9C); chk("jmp_e2_pc", instr_pc, 8'h40);
    chk("jmp_e2_valid", instr_valid, 1);

    // pc wrap at 0xFF
    tick(0, 1, 8'hFF);
    tick(0, 0, 0);
    chk("wrap_addr", imem_addr, 8'h00);
    tick(0, 0, 0);
    chk("wrap_pc_ff", instr_pc, 8'hFF); chk("wrap_code_ff", instr_code, 8'hE7);
    tick(0, 0, 0);
    chk("wrap_pc_00", instr_pc, 8'h00); chk("wrap_code_00", instr_code, 8'h0A);

    // Async reset pulse during a stall with the skid holding address 1
    tick(1, 0, 0);
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("pulse_code", instr_code, NOP);
    chk("pulse_valid", instr_valid, 0);
    chk("pulse_pc", instr_pc, 0);
    chk("pulse_addr", imem_addr, 0);
    rst = 1'b1;
    mem[3] = 8'hFF;
    tick(1, 0, 0);
    chk("post_pulse_valid", instr_valid, 0);
    stall = 1'b0;
    #1;
    chk("post_pulse_rd", imem_rd, 1);
    chk("post_pulse_addr", imem_addr, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("post_pulse_code", instr_code, 8'h0A); chk("post_pulse_ipc", instr_pc, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("pre_ff_pc", instr_pc, 2);
    tick(0, 0, 0);
    chk("ff_code", instr_code, 8'hFF); chk("ff_valid", instr_valid, 1); chk("ff_pc", instr_pc, 3);

`ifdef IFETCH_HALT_EN
    chk("ff_halted", halted, 1);
    tick(0, 1, 8'h20);
    chk("halt_code", instr_code, NOP); chk("halt_valid", instr_valid, 0);
    chk("halt_rd", imem_rd, 0); chk("halt_addr", imem_addr, 5);
    tick(1, 0, 0);
    chk("halt_stay", halted, 1); chk("halt_valid2", instr_valid, 0);
`else
    chk("ff_halted", halted, 0);
    tick(0, 0, 0);
    chk("ff_next_pc", instr_pc, 4); chk("ff_next_code", instr_code, 8'h5E);
    chk("ff_next_valid", instr_valid, 1);
    tick(0, 0, 0);
    chk("ff_next2_pc", instr_pc, 5);
`endif

    tick(0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, meaning program-counter and instruction-address width in bits.
REQ-002 The block SHALL have parameter NOP_CODE, default 8'h80 (opcode 2'b10), meaning the instruction code driven whenever no valid instruction is presented.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port stall, input, 1 bit: the downstream IF/ID stage cannot accept a new instruction this cycle.
REQ-006 The block SHALL have port jmp, input, 1 bit: redirect fetch to jmp_target this cycle.
REQ-007 The block SHALL have port jmp_target, input, PC_W bits: redirect address.
REQ-008 The block SHALL have port imem_addr, output, PC_W bits: instruction memory read address, equal to the pc register.
REQ-009 The block SHALL have port imem_rd, output, 1 bit: read request; the memory samples imem_addr at the rising edge where imem_rd=1.
REQ-010 The block SHALL have port imem_rdata, input, 8 bits: read data, valid exactly one cycle after the requesting edge.
REQ-011 The block SHALL have port instr_code, output, 8 bits, registered: instruction to IF/ID; {opcode[7:6], rd[5:3], rs[2:0]}.
REQ-012 The block SHALL have port instr_pc, output, PC_W bits, registered: address of instr_code.
REQ-013 The block SHALL have port instr_valid, output, 1 bit, registered: instr_code is a real fetched instruction.
REQ-014 The block SHALL have port halted, output, 1 bit: fetch halted (see Configuration).

Function
REQ-015 imem_rd SHALL be 1 only when state=RUN, stall=0 and jmp=0; each issued read SHALL increment pc by 1 modulo 2^PC_W (all-ones wraps to 0).
REQ-016 A response (imem_rdata one cycle after an issued read) SHALL load instr_code/instr_pc, set instr_valid=1, if stall=0 and jmp=0 at that edge, giving address-to-output latency of 2 edges.
REQ-017 A response arriving while stall=1 SHALL be captured in a 1-entry skid buffer (code, pc); the skid SHALL never hold more than one entry since imem_rd=0 under stall.
REQ-018 While stall=1 and jmp=0, instr_code, instr_pc, instr_valid and pc SHALL hold.
REQ-019 On the first edge with stall=0 after a stall, a full skid SHALL drain to the outputs and empty; imem_rd SHALL resume in that same cycle; no instruction SHALL be lost or duplicated.
REQ-020 jmp=1 SHALL take priority over stall: at that edge pc<=jmp_target, skid emptied, in-flight response discarded, instr_code<=NOP_CODE, instr_valid<=0; target instruction valid 2 edges later.
REQ-021 States: RUN (issuing), STALL (stall=1, holding), HALT (macro only); RUN->STALL on stall=1, STALL->RUN on stall=0, any->RUN on jmp=1 except HALT.
REQ-022 When instr_valid=0, instr_code SHALL equal NOP_CODE.

Reset
REQ-023 rst=0 SHALL immediately force pc=0, instr_code=NOP_CODE, instr_pc=0, instr_valid=0, skid empty, halted=0, state=RUN, independent of clk.
REQ-024 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight and buffered instructions; first read after release SHALL be address 0.

Configuration
REQ-025 With macro IFETCH_HALT_EN defined, loading 8'hFF into instr_code SHALL enter HALT: imem_rd=0, halted=1, subsequent responses discarded, jmp and stall ignored, next edge instr_code<=NOP_CODE, instr_valid<=0; only reset exits.
REQ-026 Without IFETCH_HALT_EN, 8'hFF SHALL be an ordinary instruction, HALT SHALL not exist and halted SHALL be tied 0.

Verification
REQ-027 Reset release, mem[0..2]=8'h0A,8'h53,8'h21, no stall -> instr_code 0A/53/21 with instr_pc 0/1/2 on edges 2/3/4, instr_valid=1 from edge 2.
REQ-028 Stall for 3 cycles while a response is in flight -> outputs hold, skid captures it, release yields next instruction exactly once, pc sequence gapless.
REQ-029 jmp=1, jmp_target=8'h40, same cycle as stall=1 -> 2 edges of NOP_CODE/instr_valid=0, then mem[0x40] with instr_pc=0x40.
REQ-030 pc=8'hFF issuing a read -> next imem_addr=8'h00, instr_pc of that instruction = 8'hFF then 8'h00.
REQ-031 rst=0 pulse between clock edges during a stall with full skid -> outputs reset immediately, first read after release is address 0.
REQ-032 IFETCH_HALT_EN defined, mem[3]=8'hFF -> halted=1 after it loads, imem_rd stays 0, jmp=1 ignored; macro undefined -> 8'hFF passes as valid instruction and fetch continues at 4.
